qspi_flash_responder: RTL and testbench
=======================================

Name: qspi_flash_responder

Overview:
Synthesizable QSPI flash target that answers the same read protocol the SoC QSPI flash controller issues. Used in FPGA bring-up and simulation in place of a physical flash. It decodes opcode, address and dummy phases from an oversampled SCK. Read data is served from a word-wide backing-memory port, so boot images can be loaded without real flash.

Parameters:
ADDR_BITS, 22, byte-address width of emulated flash (4 MB); wraps at 2^ADDR_BITS
JEDEC_ID, 24'hEF4018, bytes returned by 0x9F, MSB byte first
DUMMY_CYCLES, 8, SCK cycles between address and data for 0x0B/0x6B

Ports:
clk_int  in  1  system clock, >= 8x SCK frequency
rst_int  in  1  reset, asynchronous, active-high
i_qspi_sck  in  1  SPI clock from controller, mode 0
i_qspi_cs_n  in  1  chip select, active-low
i_qspi_dat  in  4  data lines from controller
o_qspi_dat  out  4  data lines to controller
o_qspi_oe  out  4  per-lane output enable
o_mem_addr  out  ADDR_BITS-2  backing-memory word address
o_mem_req  out  1  read request, held until ack
i_mem_rdata  in  32  read word, valid with ack
i_mem_ack  in  1  one-cycle read acknowledge
o_busy  out  1  high while cs_n low (synchronized)
o_cmd_err  out  1  one-cycle pulse: unsupported opcode
o_underrun  out  1  one-cycle pulse: data byte needed before word arrived

Behaviour:
- Reset: every output 0, WEL=0, FSM=IDLE, pending request cleared.
- Input handling: sck, cs_n and dat use 2-flop synchronizers plus an edge-detect register. Capture happens on synchronized SCK rise; drive changes on synchronized SCK fall. End-to-end latency is 3 clk_int cycles.
- Bit order: MSB first. Quad nibble: dat[3] = MSB. Single-line output is on dat[1] with oe=4'b0010; quad output uses oe=4'b1111.
- Byte mapping: flash byte A = word[A>>2] bits [8*(A%4)+7 : 8*(A%4)], little-endian.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
  - IDLE -> CMD on cs_n fall.
  - CMD: 8 rises on dat[0]. Then decode the opcode:
    - 0x03 -> ADDR
    - 0x0B -> ADDR
    - 0x6B -> ADDR
    - 0x05 -> DATA (status byte = {6'b0, WEL, 1'b0})
    - 0x9F -> DATA (JEDEC_ID)
    - 0x06 -> IGNORE, sets WEL
    - 0x04 -> IGNORE, clears WEL
    - Any other opcode -> IGNORE plus an o_cmd_err pulse.
  - ADDR: 24 rises on dat[0]. Keep the low ADDR_BITS bits. Issue the first word request on the 24th rise. 0x03 -> DATA; 0x0B/0x6B -> DUMMY.
  - DUMMY: DUMMY_CYCLES rises, then -> DATA.
  - DATA: the first output bit/nibble is driven on the first SCK fall after entry. Byte address increments after each byte and wraps to 0 at 2^ADDR_BITS. Status and ID repeat (status) or cycle (ID, 3 bytes) indefinitely.
  - IGNORE: oe=0 until cs_n rise.
- Prefetch: 2-word buffer (current + next). Request word+1 as soon as the current word is loaded. Only one request is outstanding at a time.
- Underrun: if a byte is needed and its word is not yet valid, drive 0xFF for that byte and pulse o_underrun.
- cs_n rise in any state: within 3 clk, FSM=IDLE, oe=0, dat=0, buffer invalidated. An outstanding o_mem_req stays high until ack, and its data is discarded.
- Simultaneous mem ack and cs_n rise: the request drops and the data is discarded.
- Async reset mid-transfer: outputs 0 immediately, independent of clk_int.

Decomposition:
- Package qspi_resp_pkg:
  - opcode localparams (OP_READ=8'h03, OP_FREAD=8'h0B, OP_QREAD=8'h6B, OP_RDSR=8'h05, OP_RDID=8'h9F, OP_WREN=8'h06, OP_WRDI=8'h04)
  - FSM state enum
  - lane-enable constants
- Sub-module: qspi_in_sync. Contains the synchronizers and sck_rise/sck_fall/cs_fall/cs_rise pulse generation.

Test Plan:
- 0x03, addr 0x000004, word[1]=0x44332211 -> dat[1] serializes bytes 11,22,33,44; o_mem_addr=1, then 2.
- 0x6B, addr 0x000002, word[0]=0xDDCCBBAA, word[1]=0x88776655, 8 dummy -> nibbles C,C,D,D,5,5,6,6 on dat[3:0]; no o_underrun.
- 0x9F, read 4 bytes -> EF,40,18,EF. 0x06 then 0x05 -> status 0x02. 0x04 then 0x05 -> 0x00.
- Opcode 0xAB -> exactly one o_cmd_err pulse; oe stays 0 until cs_n rise; next 0x05 is answered correctly.
- cs_n rise after 12 address bits -> FSM IDLE, oe=0. Then 0x03 at addr 0x3FFFFE returns bytes at 0x3FFFFE, 0x3FFFFF, then 0x000000 (wrap).
- Hold i_mem_ack off during 0x03 -> first byte 0xFF and an o_underrun pulse. Separately, assert rst_int mid-DATA -> oe=0 and o_mem_req=0 with no clk_int edge.

Source files
------------

// File: rtl/qspi_resp_pkg.sv
// Shared opcodes, FSM state encoding and lane-enable patterns for the QSPI flash responder.
package qspi_resp_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_QREAD = 8'h6B;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [3:0] OE_NONE   = 4'b0000;
  localparam logic [3:0] OE_SINGLE = 4'b0010;
  localparam logic [3:0] OE_QUAD   = 4'b1111;

  // Opcodes that carry an address and are served from backing memory.
  function automatic logic is_read_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_FREAD) || (op == OP_QREAD);
  endfunction

endpackage

// File: rtl/qspi_in_sync.sv
// Brings SCK, CS_n and data lines into the clk domain and derives one-cycle edge pulses.
module qspi_in_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic [3:0] dat,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       cs_low,
  output logic [3:0] dat_s
);

  logic       sck_m, sck_s, sck_d;
  logic       cs_m, cs_s, cs_d;
  logic [3:0] dat_m;

  // Two-flop synchronizers plus one delayed copy for edge detection; CS idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_m <= 1'b0;
      sck_s <= 1'b0;
      sck_d <= 1'b0;
      cs_m  <= 1'b1;
      cs_s  <= 1'b1;
      cs_d  <= 1'b1;
      dat_m <= '0;
      dat_s <= '0;
    end else begin
      sck_m <= sck;
      sck_s <= sck_m;
      sck_d <= sck_s;
      cs_m  <= cs_n;
      cs_s  <= cs_m;
      cs_d  <= cs_s;
      dat_m <= dat;
      dat_s <= dat_m;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_low   = ~cs_s;

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash target: decodes read/status/ID commands and serves read data from a word memory port.
module qspi_flash_responder #(
  parameter int unsigned ADDR_BITS    = 22,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
  parameter int unsigned DUMMY_CYCLES = 8
) (
  input  logic                 clk_int,
  input  logic                 rst_int,
  input  logic                 i_qspi_sck,
  input  logic                 i_qspi_cs_n,
  input  logic [3:0]           i_qspi_dat,
  output logic [3:0]           o_qspi_dat,
  output logic [3:0]           o_qspi_oe,
  output logic [ADDR_BITS-3:0] o_mem_addr,
  output logic                 o_mem_req,
  input  logic [31:0]          i_mem_rdata,
  input  logic                 i_mem_ack,
  output logic                 o_busy,
  output logic                 o_cmd_err,
  output logic                 o_underrun
);
  import qspi_resp_pkg::*;

  localparam int unsigned WA = ADDR_BITS - 2;
  localparam logic [4:0]  DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

  logic           sck_rise, sck_fall, cs_fall, cs_rise, cs_low;
  logic [3:0]     din;
  logic           unused_din;
  state_t         state, state_nx;
  logic [4:0]     cnt;
  logic [ADDR_BITS-2:0] sr;
  logic [7:0]     op, opcode_now, byte_now, out_sr;
  logic [ADDR_BITS-1:0] addr, addr_now;
  logic [WA-1:0]  cur_waddr, eff_waddr, nxt_waddr;
  logic           wel, cur_valid, nxt_valid, rd_active, req_live;
  logic [1:0]     id_idx;
  logic [31:0]    cur_word, nxt_word;
  logic [2:0]     out_cnt;
  logic           cmd_done, addr_done, dummy_done, take_byte, quad, word_adv, ack_cur, ack_nxt;

  qspi_in_sync u_sync (
    .clk      (clk_int),
    .rst      (rst_int),
    .sck      (i_qspi_sck),
    .cs_n     (i_qspi_cs_n),
    .dat      (i_qspi_dat),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .cs_low   (cs_low),
    .dat_s    (din)
  );

  // Commands and addresses arrive on lane 0 only.
  assign unused_din = ^din[3:1];

  // Phase decode and next-state selection; a CS rise overrides everything.
  always_comb begin
    opcode_now = {sr[6:0], din[0]};
    addr_now   = {sr, din[0]};
    cmd_done   = (state == ST_CMD)   && sck_rise && (cnt == 5'd7);
    addr_done  = (state == ST_ADDR)  && sck_rise && (cnt == 5'd23);
    dummy_done = (state == ST_DUMMY) && sck_rise && (cnt == DUMMY_LAST);
    state_nx   = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_nx = ST_CMD;
      ST_CMD:   if (cmd_done) begin
                  if (is_read_op(opcode_now))                             state_nx = ST_ADDR;
                  else if (opcode_now == OP_RDSR || opcode_now == OP_RDID) state_nx = ST_DATA;
                  else                                                     state_nx = ST_IGNORE;
                end
      ST_ADDR:  if (addr_done)
                  state_nx = (op == OP_READ || DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
      ST_DUMMY: if (dummy_done) state_nx = ST_DATA;
      default:  state_nx = state;
    endcase
    if (cs_rise) state_nx = ST_IDLE;
  end

  // Byte selection and prefetch bookkeeping; an ack is matched against the
  // word address as it will be after any word advance in the same cycle.
  always_comb begin
    quad      = (op == OP_QREAD);
    take_byte = (state == ST_DATA) && sck_fall && (out_cnt == 3'd0);
    cur_waddr = addr[ADDR_BITS-1:2];
    word_adv  = take_byte && is_read_op(op) && (addr[1:0] == 2'b11);
    eff_waddr = word_adv ? cur_waddr + WA'(1) : cur_waddr;
    nxt_waddr = eff_waddr + WA'(1);
    ack_cur   = i_mem_ack && o_mem_req && req_live && (o_mem_addr == eff_waddr);
    ack_nxt   = i_mem_ack && o_mem_req && req_live && (o_mem_addr == nxt_waddr);
    byte_now  = 8'hFF;
    if (op == OP_RDSR) begin
      byte_now = {6'b0, wel, 1'b0};
    end else if (op == OP_RDID) begin
      case (id_idx)
        2'd0:    byte_now = JEDEC_ID[23:16];
        2'd1:    byte_now = JEDEC_ID[15:8];
        default: byte_now = JEDEC_ID[7:0];
      endcase
    end else if (cur_valid) begin
      case (addr[1:0])
        2'd0:    byte_now = cur_word[7:0];
        2'd1:    byte_now = cur_word[15:8];
        2'd2:    byte_now = cur_word[23:16];
        default: byte_now = cur_word[31:24];
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Shift-in, output serialization, prefetch buffer and memory request handling.
  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int) begin
      o_qspi_dat <= '0;
      o_qspi_oe  <= OE_NONE;
      o_mem_addr <= '0;
      o_mem_req  <= 1'b0;
      o_busy     <= 1'b0;
      o_cmd_err  <= 1'b0;
      o_underrun <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      op         <= '0;
      wel        <= 1'b0;
      addr       <= '0;
      id_idx     <= '0;
      cur_word   <= '0;
      nxt_word   <= '0;
      cur_valid  <= 1'b0;
      nxt_valid  <= 1'b0;
      rd_active  <= 1'b0;
      req_live   <= 1'b0;
      out_sr     <= '0;
      out_cnt    <= '0;
    end else begin
      o_cmd_err  <= 1'b0;
      o_underrun <= 1'b0;
      o_busy     <= cs_low;

      if (sck_rise && (state inside {ST_CMD, ST_ADDR, ST_DUMMY})) begin
        sr  <= {sr[ADDR_BITS-3:0], din[0]};
        cnt <= cnt + 5'd1;
      end
      if (cs_fall) cnt <= '0;

      if (cmd_done) begin
        cnt     <= '0;
        op      <= opcode_now;
        id_idx  <= '0;
        out_cnt <= '0;
        if (opcode_now == OP_WREN)      wel <= 1'b1;
        else if (opcode_now == OP_WRDI) wel <= 1'b0;
        else if (!is_read_op(opcode_now) && opcode_now != OP_RDSR && opcode_now != OP_RDID)
          o_cmd_err <= 1'b1;
      end

      if (addr_done) begin
        cnt       <= '0;
        addr      <= addr_now;
        rd_active <= 1'b1;
        cur_valid <= 1'b0;
        nxt_valid <= 1'b0;
        if (!o_mem_req) begin
          o_mem_req  <= 1'b1;
          o_mem_addr <= addr_now[ADDR_BITS-1:2];
          req_live   <= 1'b1;
        end
      end

      if (take_byte) begin
        o_qspi_oe <= quad ? OE_QUAD : OE_SINGLE;
        if (quad) begin
          o_qspi_dat <= byte_now[7:4];
          out_sr     <= {byte_now[3:0], 4'b0};
          out_cnt    <= 3'd1;
        end else begin
          o_qspi_dat <= {2'b00, byte_now[7], 1'b0};
          out_sr     <= {byte_now[6:0], 1'b0};
          out_cnt    <= 3'd7;
        end
        if (op == OP_RDID) id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
        if (is_read_op(op)) begin
          addr <= addr + ADDR_BITS'(1);
          if (!cur_valid) o_underrun <= 1'b1;
          if (word_adv) begin
            cur_word  <= nxt_word;
            cur_valid <= nxt_valid;
            nxt_valid <= 1'b0;
          end
        end
      end else if (state == ST_DATA && sck_fall) begin
        o_qspi_dat <= quad ? out_sr[7:4] : {2'b00, out_sr[7], 1'b0};
        out_sr     <= quad ? {out_sr[3:0], 4'b0} : {out_sr[6:0], 1'b0};
        out_cnt    <= out_cnt - 3'd1;
      end

      if (o_mem_req && i_mem_ack) begin
        o_mem_req <= 1'b0;
        req_live  <= 1'b0;
        if (ack_cur) begin
          cur_word  <= i_mem_rdata;
          cur_valid <= 1'b1;
        end else if (ack_nxt) begin
          nxt_word  <= i_mem_rdata;
          nxt_valid <= 1'b1;
        end
      end else if (!o_mem_req && rd_active && !take_byte && !addr_done) begin
        if (!cur_valid) begin
          o_mem_req  <= 1'b1;
          o_mem_addr <= cur_waddr;
          req_live   <= 1'b1;
        end else if (!nxt_valid) begin
          o_mem_req  <= 1'b1;
          o_mem_addr <= cur_waddr + WA'(1);
          req_live   <= 1'b1;
        end
      end

      // End of transaction: an in-flight request completes but its data is dropped.
      if (cs_rise) begin
        o_qspi_oe  <= OE_NONE;
        o_qspi_dat <= '0;
        cur_valid  <= 1'b0;
        nxt_valid  <= 1'b0;
        rd_active  <= 1'b0;
        req_live   <= 1'b0;
        out_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench: table of command transactions plus hand sequences for abort, underrun and reset.
module tb_qspi_flash_responder;

  logic        clk_int = 1'b0;
  logic        rst_int;
  logic        i_qspi_sck, i_qspi_cs_n;
  logic [3:0]  i_qspi_dat;
  logic [3:0]  o_qspi_dat, o_qspi_oe;
  logic [19:0] o_mem_addr;
  logic        o_mem_req;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_busy, o_cmd_err, o_underrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [logic [19:0]];
  logic        mem_en;
  int          lat;
  int          err_cnt = 0;
  int          urun_cnt = 0;
  logic [19:0] req_log [$];

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nbytes;
    logic [31:0] exp;
    logic [3:0]  exp_oe;
    int          exp_err;
    logic [19:0] wa;
    logic [31:0] wd0;
    logic [31:0] wd1;
  } vec_t;

  vec_t tbl [11];

  qspi_flash_responder #(.ADDR_BITS(22), .JEDEC_ID(24'hEF4018), .DUMMY_CYCLES(8)) dut (
    .clk_int     (clk_int),
    .rst_int     (rst_int),
    .i_qspi_sck  (i_qspi_sck),
    .i_qspi_cs_n (i_qspi_cs_n),
    .i_qspi_dat  (i_qspi_dat),
    .o_qspi_dat  (o_qspi_dat),
    .o_qspi_oe   (o_qspi_oe),
    .o_mem_addr  (o_mem_addr),
    .o_mem_req   (o_mem_req),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ack   (i_mem_ack),
    .o_busy      (o_busy),
    .o_cmd_err   (o_cmd_err),
    .o_underrun  (o_underrun)
  );

  always #5 clk_int = ~clk_int;

  // Memory responder (ack on the third cycle of a request) and pulse counters.
  always @(negedge clk_int) begin
    if (o_cmd_err)  err_cnt++;
    if (o_underrun) urun_cnt++;
    i_mem_ack = 1'b0;
    if (o_mem_req && mem_en) begin
      if (lat == 2) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : 32'h0;
        req_log.push_back(o_mem_addr);
        lat = 0;
      end else begin
        lat++;
      end
    end else begin
      lat = 0;
    end
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, req);
    end
  endtask

  // One SCK period: present data, sample DUT lines just before the rise, then rise and fall.
  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    i_qspi_dat = d;
    #80;
    q  = o_qspi_dat;
    oe = o_qspi_oe;
    i_qspi_sck = 1'b1;
    #80;
    i_qspi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    logic [3:0] q, oe;
    for (int i = n - 1; i >= 0; i--) sck_cycle({3'b000, v[i]}, q, oe);
  endtask

  task automatic read_byte(input logic is_quad, output logic [7:0] b, output logic [3:0] oe_seen);
    logic [3:0] q, oe;
    b = '0;
    oe_seen = '0;
    if (is_quad) begin
      for (int i = 0; i < 2; i++) begin
        sck_cycle(4'h0, q, oe);
        b = {b[3:0], q};
        oe_seen = oe;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        sck_cycle(4'h0, q, oe);
        b = {b[6:0], q[1]};
        oe_seen = oe;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          e0, u0, r0;
    logic [7:0]  got, eb;
    logic [3:0]  oe;
    logic [19:0] w0, w1;
    logic        rd;
    rd = (v.op == 8'h03) || (v.op == 8'h0B) || (v.op == 8'h6B);
    if (rd) begin
      mem[v.wa] = v.wd0;
      w1 = v.wa + 20'd1;
      mem[w1] = v.wd1;
    end
    e0 = err_cnt;
    u0 = urun_cnt;
    r0 = req_log.size();
    i_qspi_cs_n = 1'b0;
    #160;
    check("busy_low_cs", idx, {31'b0, o_busy}, 32'd1);
    send_bits({16'b0, v.op}, 8);
    if (rd) send_bits(v.addr, 24);
    if (v.op == 8'h0B || v.op == 8'h6B) send_bits(24'h0, 8);
    for (int b = 0; b < v.nbytes; b++) begin
      read_byte(v.op == 8'h6B, got, oe);
      eb = v.exp[31 - 8*b -: 8];
      check("data_byte", idx * 10 + b, {24'b0, got}, {24'b0, eb});
      check("data_oe", idx * 10 + b, {28'b0, oe}, {28'b0, v.exp_oe});
    end
    #80;
    i_qspi_cs_n = 1'b1;
    #240;
    check("oe_after_cs", idx, {28'b0, o_qspi_oe}, 32'd0);
    check("busy_after_cs", idx, {31'b0, o_busy}, 32'd0);
    check("cmd_err_pulses", idx, err_cnt - e0, v.exp_err);
    check("underrun_pulses", idx, urun_cnt - u0, 32'd0);
    if (rd) begin
      w0 = v.addr[21:2];
      w1 = w0 + 20'd1;
      if (req_log.size() >= r0 + 2) begin
        check("first_req_addr", idx, {12'b0, req_log[r0]}, {12'b0, w0});
        check("second_req_addr", idx, {12'b0, req_log[r0 + 1]}, {12'b0, w1});
      end else begin
        check("req_count", idx, req_log.size() - r0, 32'd2);
      end
    end
  endtask

  initial begin
    logic [7:0] got;
    logic [3:0] oe;
    int         u0;

    //           op     addr        n  exp            oe       err wa        wd0           wd1
    tbl[0]  = '{8'h03, 24'h000004, 4, 32'h11223344, 4'b0010, 0, 20'h00001, 32'h44332211, 32'h00000000};
    tbl[1]  = '{8'h6B, 24'h000002, 4, 32'hCCDD5566, 4'b1111, 0, 20'h00000, 32'hDDCCBBAA, 32'h88776655};
    tbl[2]  = '{8'h9F, 24'h000000, 4, 32'hEF4018EF, 4'b0010, 0, 20'h00000, 32'h0,        32'h0};
    tbl[3]  = '{8'h06, 24'h000000, 0, 32'h00000000, 4'b0000, 0, 20'h00000, 32'h0,        32'h0};
    tbl[4]  = '{8'h05, 24'h000000, 2, 32'h02020000, 4'b0010, 0, 20'h00000, 32'h0,        32'h0};
    tbl[5]  = '{8'h04, 24'h000000, 0, 32'h00000000, 4'b0000, 0, 20'h00000, 32'h0,        32'h0};
    tbl[6]  = '{8'h05, 24'h000000, 2, 32'h00000000, 4'b0010, 0, 20'h00000, 32'h0,        32'h0};
    tbl[7]  = '{8'hAB, 24'h000000, 2, 32'h00000000, 4'b0000, 1, 20'h00000, 32'h0,        32'h0};
    tbl[8]  = '{8'h05, 24'h000000, 2, 32'h00000000, 4'b0010, 0, 20'h00000, 32'h0,        32'h0};
    tbl[9]  = '{8'h0B, 24'h000005, 4, 32'h66778809, 4'b0010, 0, 20'h00001, 32'h88776655, 32'h0C0B0A09};
    tbl[10] = '{8'h03, 24'h3FFFFE, 4, 32'h5B5AC300, 4'b0010, 0, 20'hFFFFF, 32'h5A5B5C5D, 32'h000000C3};

    rst_int     = 1'b1;
    i_qspi_sck  = 1'b0;
    i_qspi_cs_n = 1'b1;
    i_qspi_dat  = 4'h0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    mem_en      = 1'b1;
    lat         = 0;
    #20;
    check("rst_oe", 0, {28'b0, o_qspi_oe}, 32'd0);
    check("rst_dat", 0, {28'b0, o_qspi_dat}, 32'd0);
    check("rst_req", 0, {31'b0, o_mem_req}, 32'd0);
    check("rst_busy", 0, {31'b0, o_busy}, 32'd0);
    check("rst_pulses", 0, {30'b0, o_cmd_err, o_underrun}, 32'd0);
    rst_int = 1'b0;
    #100;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

    // Abort a read after 12 address bits; no request may be issued and lines stay released.
    i_qspi_cs_n = 1'b0;
    #160;
    send_bits(24'h000003, 8);
    send_bits(24'h000ABC, 12);
    #80;
    i_qspi_cs_n = 1'b1;
    #240;
    check("abort_oe", 0, {28'b0, o_qspi_oe}, 32'd0);
    check("abort_req", 0, {31'b0, o_mem_req}, 32'd0);
    check("abort_busy", 0, {31'b0, o_busy}, 32'd0);
    run_vec(tbl[10], 11);

    // Memory withheld: first byte must read as 0xFF with one underrun pulse.
    mem[20'h00004] = 32'h12345678;
    mem_en = 1'b0;
    u0 = urun_cnt;
    i_qspi_cs_n = 1'b0;
    #160;
    send_bits(24'h000003, 8);
    send_bits(24'h000010, 24);
    read_byte(1'b0, got, oe);
    check("underrun_byte", 0, {24'b0, got}, 32'h000000FF);
    check("underrun_oe", 0, {28'b0, oe}, 32'h00000002);
    check("underrun_pulse", 0, urun_cnt - u0, 32'd1);
    check("underrun_req_held", 0, {31'b0, o_mem_req}, 32'd1);
    #80;
    i_qspi_cs_n = 1'b1;
    #240;
    mem_en = 1'b1;
    #400;
    check("stale_req_done", 0, {31'b0, o_mem_req}, 32'd0);
    check("stale_oe", 0, {28'b0, o_qspi_oe}, 32'd0);

    // Asynchronous reset in the middle of a data phase.
    mem_en = 1'b0;
    i_qspi_cs_n = 1'b0;
    #160;
    send_bits(24'h000003, 8);
    send_bits(24'h000020, 24);
    sck_cycle(4'h0, oe, oe);
    sck_cycle(4'h0, oe, oe);
    @(posedge clk_int);
    #2;
    check("pre_rst_oe", 0, {28'b0, o_qspi_oe}, 32'h00000002);
    check("pre_rst_req", 0, {31'b0, o_mem_req}, 32'd1);
    rst_int = 1'b1;
    #1;
    check("async_rst_oe", 0, {28'b0, o_qspi_oe}, 32'd0);
    check("async_rst_req", 0, {31'b0, o_mem_req}, 32'd0);
    check("async_rst_dat", 0, {28'b0, o_qspi_dat}, 32'd0);
    check("async_rst_busy", 0, {31'b0, o_busy}, 32'd0);
    i_qspi_cs_n = 1'b1;
    mem_en = 1'b1;
    #20;
    rst_int = 1'b0;
    #200;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
